// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if -- handshake/data bundle for sync_fifo.
//   master : drives flush, wr, re, data_in; observes data and status.
//   slave  : the FIFO itself; drives data_out, full, empty, almost_full,
//            almost_empty, count, overflow, underflow.
// DEPTH and DWIDTH must match the sync_fifo instance they connect to.
// ---------------------------------------------------------------------------
interface sync_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              wr;
  logic              re;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr, re, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr, re, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty levels, sticky overflow/underflow flags and a
// choice of registered (FWFT=0) or first-word-fall-through (FWFT=1) output.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-low
//   bus    : sync_fifo_if.slave (flush, wr, re, data_in in;
//            data_out, full, empty, almost_full, almost_empty, count,
//            overflow, underflow out)
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH     = 8,
  parameter int DWIDTH    = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic         clk,
  input  logic         reset,
  sync_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  // Pointers carry one wrap bit above the index so that equal indices with
  // different wrap bits mean full and identical pointers mean empty.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              wr_acc, rd_acc;
  logic [AW-1:0]     rd_idx;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Occupancy is the pointer distance; modular subtraction handles wrap.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == FULL_LVL);
  assign empty  = (count == '0);
  assign rd_idx = rd_ptr_q[AW-1:0];

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_LVL);
  assign bus.almost_empty = (count <= AE_LVL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  always_comb begin
    wr_acc      = bus.wr && !full  && !bus.flush;
    rd_acc      = bus.re && !empty && !bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q  | (bus.wr && full);
    underflow_d = underflow_q | (bus.re && empty);
    if (bus.flush) begin
      // Flush masks the same-cycle access, including its sticky effects.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only a write accepted outside reset lands.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT == 0) begin : g_reg_out
      logic [DWIDTH-1:0] data_out_q, data_out_d;

      always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) data_out_d = mem_q[rd_idx];
      end

      always_ff @(posedge clk) begin
        if (!reset) data_out_q <= '0;
        else        data_out_q <= data_out_d;
      end

      assign bus.data_out = data_out_q;
    end else begin : g_fwft_out
      // Head entry shown directly; content is meaningless while empty.
      assign bus.data_out = mem_q[rd_idx];
    end
  endgenerate

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of storage entries; power of two, >= 2.
REQ-002 Parameter DWIDTH, default 16: data word width in bits.
REQ-003 Parameter AF_THRESH, default DEPTH-2: almost_full threshold, 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = registered read data, 1 = first-word-fall-through.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-008 flush  in  1  synchronous empty request.
REQ-009 wr  in  1  write request.
REQ-010 re  in  1  read request.
REQ-011 data_in  in  DWIDTH  write data.
REQ-012 data_out  out  DWIDTH  read data.
REQ-013 full  out  1  count == DEPTH.
REQ-014 empty  out  1  count == 0.
REQ-015 almost_full  out  1  count >= AF_THRESH.
REQ-016 almost_empty  out  1  count <= AE_THRESH.
REQ-017 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 overflow  out  1  sticky: write attempted while full.
REQ-019 underflow  out  1  sticky: read attempted while empty.

Function
REQ-020 Write accepted iff wr=1 and full=0; data_in stored at write pointer, pointer increments modulo DEPTH.
REQ-021 Read accepted iff re=1 and empty=0; read pointer increments modulo DEPTH.
REQ-022 All DEPTH entries usable; pointers carry one extra wrap bit so full and empty are distinguishable.
REQ-023 count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or no access.
REQ-024 Simultaneous wr and re when empty: read rejected, write accepted, count 0->1, underflow set.
REQ-025 Simultaneous wr and re when full: write rejected, read accepted, count DEPTH->DEPTH-1, overflow set.
REQ-026 Status outputs full, empty, almost_full, almost_empty are combinational from count, reflecting state after the last clock edge.
REQ-027 overflow sets on any cycle with wr=1 and full=1; underflow sets on any cycle with re=1 and empty=1; both hold until reset or flush.
REQ-028 FWFT=0: data_out loads head entry on the edge accepting a read (valid the cycle after); otherwise holds last value.
REQ-029 FWFT=1: data_out continuously presents the head entry; valid whenever empty=0; accepted read advances to next entry on same edge; undefined content when empty.
REQ-030 flush=1: pointers, count, overflow, underflow cleared on that edge; wr and re in same cycle ignored and do not set sticky flags; storage contents and FWFT=0 data_out unchanged.
REQ-031 Priority per edge: reset, then flush, then read/write.
REQ-032 Pointer wrap from DEPTH-1 to 0 is seamless; ordering preserved across wrap.

Reset
REQ-033 reset=0 at a rising edge: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0, pointers=0, FWFT=0 data_out=0.
REQ-034 Reset mid-operation discards all stored entries; wr/re in the reset cycle ignored; storage array not cleared.
REQ-035 First access honoured on the first edge with reset=1.

Verification
REQ-036 DEPTH=8, FWFT=0: write 0x0001..0x0008 -> full=1 after 8th, count=8; read 8 -> data_out 0x0001..0x0008 each one cycle after re, empty=1.
REQ-037 Full FIFO, wr=1 re=1 one cycle -> count=7, overflow=1, head 0x0001 read; 9th word not stored.
REQ-038 Empty FIFO, wr=1 re=1 with data_in=0xABCD -> count=1, underflow=1; next read returns 0xABCD.
REQ-039 Write/read 20 words at one per cycle through DEPTH=8 -> output order 1..20 across pointer wrap, count never exceeds 1.
REQ-040 AF_THRESH=6, AE_THRESH=1: fill 0..8 -> almost_empty=1 at count 0,1; almost_full=1 at count 6..8.
REQ-041 FWFT=1: write 0x1111 -> data_out=0x1111 next cycle with no re; flush with count=5 -> count=0, empty=1, flags clear; reset=0 mid-fill -> all REQ-033 values.
